// File: rtl/btn_evt.sv
// btn_evt: turns debounced button levels into press/release/long-press events
// and queues them in a 4-entry first-word-fall-through queue for a ready/valid consumer.
module btn_evt #(
    parameter int unsigned BT_WIDTH   = 8,
    parameter int unsigned KEY_W      = 3,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter logic [25:0] HOLD_CYC   = 26'd50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BT_WIDTH-1:0] btn_in,
    output logic                evt_valid,
    output logic [1:0]          evt_type,
    output logic [KEY_W-1:0]    evt_key,
    input  logic                evt_ready,
    output logic [BT_WIDTH-1:0] btn_state,
    output logic                ovf
);

    localparam int unsigned QDEPTH = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned EW     = KEY_W + 2;
    localparam int unsigned HOLD_W = 26;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;

    typedef enum logic [1:0] {
        TRK_IDLE = 2'b00,
        TRK_RUN  = 2'b01,
        TRK_DONE = 2'b10
    } trk_state_t;

    logic [BT_WIDTH-1:0] btn_state_q, btn_state_d;
    logic [BT_WIDTH-1:0] btn_prev_q,  btn_prev_d;
    logic [BT_WIDTH-1:0] press_pend_q, press_pend_d;
    logic [BT_WIDTH-1:0] rel_pend_q,   rel_pend_d;
    logic                long_pend_q,  long_pend_d;
    logic [KEY_W-1:0]    long_key_q,   long_key_d;
    logic                ovf_q,        ovf_d;

    trk_state_t          trk_state_q,  trk_state_d;
    logic [KEY_W-1:0]    trk_key_q,    trk_key_d;
    logic [HOLD_W-1:0]   hold_cnt_q,   hold_cnt_d;

    logic [EW-1:0]       mem_q [QDEPTH];
    logic [EW-1:0]       mem_d [QDEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                evt_valid_q, evt_valid_d;
    logic [1:0]          evt_type_q,  evt_type_d;
    logic [KEY_W-1:0]    evt_key_q,   evt_key_d;

    logic [BT_WIDTH-1:0] rise, fall, rel_elig;
    logic [BT_WIDTH-1:0] clr_press, clr_rel;
    logic                clr_long, long_set;
    logic                pop, can_push, issue;
    logic [1:0]          new_type;
    logic [KEY_W-1:0]    new_key;
    logic [EW-1:0]       head;

    function automatic logic [KEY_W-1:0] lowest_idx(input logic [BT_WIDTH-1:0] v);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = int'(BT_WIDTH) - 1; i >= 0; i--) begin
            if (v[i]) idx = KEY_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [BT_WIDTH-1:0] lowest_onehot(input logic [BT_WIDTH-1:0] v);
        return v & (~v + BT_WIDTH'(1));
    endfunction

    always_comb begin
        btn_state_d  = btn_in ^ {BT_WIDTH{ACTIVE_LOW}};
        btn_prev_d   = btn_state_q;
        rise         = btn_state_q & ~btn_prev_q;
        fall         = ~btn_state_q & btn_prev_q;
        rel_elig     = rel_pend_q & ~press_pend_q;

        issue        = 1'b0;
        new_type     = EVT_PRESS;
        new_key      = '0;
        clr_press    = '0;
        clr_rel      = '0;
        clr_long     = 1'b0;
        long_set     = 1'b0;

        trk_state_d  = trk_state_q;
        trk_key_d    = trk_key_q;
        hold_cnt_d   = hold_cnt_q;

        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;

        pop      = evt_valid_q & evt_ready;
        can_push = (cnt_q != CNT_W'(QDEPTH)) || pop;

        // Arbiter: long > lowest release (not shadowed by its own press) > lowest press
        if (can_push) begin
            if (long_pend_q) begin
                issue    = 1'b1;
                new_type = EVT_LONG;
                new_key  = long_key_q;
                clr_long = 1'b1;
            end else if (|rel_elig) begin
                issue    = 1'b1;
                new_type = EVT_RELEASE;
                new_key  = lowest_idx(rel_elig);
                clr_rel  = lowest_onehot(rel_elig);
            end else if (|press_pend_q) begin
                issue     = 1'b1;
                new_type  = EVT_PRESS;
                new_key   = lowest_idx(press_pend_q);
                clr_press = lowest_onehot(press_pend_q);
            end
        end

        press_pend_d = (press_pend_q & ~clr_press) | rise;
        rel_pend_d   = (rel_pend_q & ~clr_rel) | fall;
        ovf_d        = ovf_q
                     | (|(rise & press_pend_q & ~clr_press))
                     | (|(fall & rel_pend_q & ~clr_rel));

        // Long-press tracker follows a single key until that key is released
        unique case (trk_state_q)
            TRK_IDLE: begin
                if (|btn_state_q) begin
                    trk_key_d   = lowest_idx(btn_state_q);
                    hold_cnt_d  = '0;
                    trk_state_d = TRK_RUN;
                end
            end
            TRK_RUN: begin
                if (!btn_state_q[trk_key_q]) begin
                    trk_state_d = TRK_IDLE;
                end else if (hold_cnt_q == HOLD_CYC - 26'd1) begin
                    long_set    = 1'b1;
                    trk_state_d = TRK_DONE;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 26'd1;
                end
            end
            TRK_DONE: begin
                if (!btn_state_q[trk_key_q]) trk_state_d = TRK_IDLE;
            end
            default: trk_state_d = TRK_IDLE;
        endcase

        long_pend_d = (long_pend_q & ~clr_long) | long_set;
        long_key_d  = long_set ? trk_key_q : long_key_q;

        if (issue) begin
            mem_d[wr_ptr_q] = {new_type, new_key};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({issue, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Head word is registered so the outputs come straight from flops
        head        = mem_d[rd_ptr_d];
        evt_valid_d = (cnt_d != '0);
        evt_type_d  = evt_valid_d ? head[EW-1 -: 2] : 2'b00;
        evt_key_d   = evt_valid_d ? head[KEY_W-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_state_q  <= '0;
            btn_prev_q   <= '0;
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            long_pend_q  <= 1'b0;
            long_key_q   <= '0;
            ovf_q        <= 1'b0;
            trk_state_q  <= TRK_IDLE;
            trk_key_q    <= '0;
            hold_cnt_q   <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            evt_valid_q  <= 1'b0;
            evt_type_q   <= 2'b00;
            evt_key_q    <= '0;
        end else begin
            btn_state_q  <= btn_state_d;
            btn_prev_q   <= btn_prev_d;
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            long_pend_q  <= long_pend_d;
            long_key_q   <= long_key_d;
            ovf_q        <= ovf_d;
            trk_state_q  <= trk_state_d;
            trk_key_q    <= trk_key_d;
            hold_cnt_q   <= hold_cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            evt_valid_q  <= evt_valid_d;
            evt_type_q   <= evt_type_d;
            evt_key_q    <= evt_key_d;
        end
    end

    assign btn_state = btn_state_q;
    assign ovf       = ovf_q;
    assign evt_valid = evt_valid_q;
    assign evt_type  = evt_type_q;
    assign evt_key   = evt_key_q;

endmodule

// File: tb/tb_btn_evt.sv
// Bench for btn_evt: a directed vector table, hand-written corner sequences and a
// randomized run compared every cycle against an event-level reference model.
module tb_btn_evt;

    localparam int HOLD = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] btn_in;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [2:0] evt_key;
    logic [7:0] btn_state;
    logic       ovf;

    btn_evt #(
        .BT_WIDTH  (8),
        .KEY_W     (3),
        .ACTIVE_LOW(1'b1),
        .HOLD_CYC  (26'd100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .evt_valid(evt_valid),
        .evt_type (evt_type),
        .evt_key  (evt_key),
        .evt_ready(evt_ready),
        .btn_state(btn_state),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (event level) ----------------
    typedef struct { int t; int k; } ev_t;
    ev_t      m_q[$];
    bit [7:0] m_state, m_prev;
    bit       m_pp[8];
    bit       m_rp[8];
    bit       m_long;
    int       m_long_key;
    int       m_trk;
    int       m_hold;
    bit       m_done;
    bit       m_ovf;

    task automatic model_step();
        bit  pop, room, issue, cl, rise, fall;
        int  cp, cr, lo;
        ev_t e;
        if (rst) begin
            m_q.delete();
            m_state = '0; m_prev = '0;
            for (int k = 0; k < 8; k++) begin m_pp[k] = 1'b0; m_rp[k] = 1'b0; end
            m_long = 1'b0; m_long_key = 0; m_trk = -1; m_hold = 0; m_done = 1'b0; m_ovf = 1'b0;
            return;
        end
        pop   = (m_q.size() > 0) && (evt_ready === 1'b1);
        room  = (m_q.size() < 4) || pop;
        issue = 1'b0; cl = 1'b0; cp = -1; cr = -1;
        e = '{0, 0};
        if (room) begin
            if (m_long) begin
                issue = 1'b1; e = '{2, m_long_key}; cl = 1'b1;
            end else begin
                for (int k = 7; k >= 0; k--) if (m_rp[k] && !m_pp[k]) cr = k;
                if (cr >= 0) begin
                    issue = 1'b1; e = '{1, cr};
                end else begin
                    for (int k = 7; k >= 0; k--) if (m_pp[k]) cp = k;
                    if (cp >= 0) begin issue = 1'b1; e = '{0, cp}; end
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            rise = m_state[k] && !m_prev[k];
            fall = !m_state[k] && m_prev[k];
            if (rise && m_pp[k] && k != cp) m_ovf = 1'b1;
            if (fall && m_rp[k] && k != cr) m_ovf = 1'b1;
            if (k == cp) m_pp[k] = 1'b0;
            if (k == cr) m_rp[k] = 1'b0;
            if (rise) m_pp[k] = 1'b1;
            if (fall) m_rp[k] = 1'b1;
        end
        if (cl) m_long = 1'b0;
        if (m_trk < 0) begin
            if (m_state != 0) begin
                lo = 0;
                for (int k = 7; k >= 0; k--) if (m_state[k]) lo = k;
                m_trk = lo; m_hold = 0; m_done = 1'b0;
            end
        end else if (!m_state[m_trk]) begin
            m_trk = -1;
        end else if (!m_done) begin
            if (m_hold == HOLD - 1) begin
                m_long = 1'b1; m_long_key = m_trk; m_done = 1'b1;
            end else begin
                m_hold++;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (issue) m_q.push_back(e);
        m_prev  = m_state;
        m_state = ~btn_in;
    endtask

    always @(posedge clk) model_step();

    task automatic compare_cycle();
        logic [14:0] exp_v, act_v;
        bit          v;
        v     = (m_q.size() > 0);
        exp_v = {v, v ? 2'(m_q[0].t) : 2'd0, v ? 3'(m_q[0].k) : 3'd0, m_state, m_ovf};
        act_v = {evt_valid, evt_type, evt_key, btn_state, ovf};
        check("model{vld,typ,key,state,ovf}", 32'(act_v), 32'(exp_v));
    endtask

    always @(negedge clk) if (chk_en) compare_cycle();

    // ---------------- accepted-event log ----------------
    typedef struct { int t; int k; int c; } log_t;
    log_t lg[$];

    always @(negedge clk)
        if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1)
            lg.push_back('{int'(evt_type), int'(evt_key), cyc});

    task automatic check_log(input string name, input int idx, input int t, input int k);
        logic [31:0] act;
        act = (idx < lg.size()) ? 32'(lg[idx].t * 256 + lg[idx].k) : 32'hFFFF_FFFF;
        check(name, act, 32'(t * 256 + k));
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] btn;
        logic       rdy;
        logic       vld;
        logic [1:0] typ;
        logic [2:0] key;
        logic [7:0] st;
    } vec_t;

    initial begin
        vec_t vecs[21];
        int   b;

        vecs[0]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00};
        vecs[1]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00};
        vecs[2]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00};
        vecs[3]  = '{1'b0, 8'hFB, 1'b1, 1'b0, 2'd0, 3'd0, 8'h04};
        vecs[4]  = '{1'b0, 8'hFB, 1'b1, 1'b0, 2'd0, 3'd0, 8'h04};
        vecs[5]  = '{1'b0, 8'hFB, 1'b1, 1'b1, 2'd0, 3'd2, 8'h04};
        vecs[6]  = '{1'b0, 8'hFB, 1'b1, 1'b0, 2'd0, 3'd0, 8'h04};
        vecs[7]  = '{1'b0, 8'hFB, 1'b1, 1'b0, 2'd0, 3'd0, 8'h04};
        vecs[8]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00};
        vecs[9]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00};
        vecs[10] = '{1'b0, 8'hFF, 1'b1, 1'b1, 2'd1, 3'd2, 8'h00};
        vecs[11] = '{1'b0, 8'hFF, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00};
        vecs[12] = '{1'b0, 8'hFE, 1'b0, 1'b0, 2'd0, 3'd0, 8'h01};
        vecs[13] = '{1'b0, 8'hFE, 1'b0, 1'b0, 2'd0, 3'd0, 8'h01};
        vecs[14] = '{1'b0, 8'hFE, 1'b0, 1'b1, 2'd0, 3'd0, 8'h01};
        vecs[15] = '{1'b0, 8'hFE, 1'b0, 1'b1, 2'd0, 3'd0, 8'h01};
        vecs[16] = '{1'b0, 8'hFE, 1'b1, 1'b0, 2'd0, 3'd0, 8'h01};
        vecs[17] = '{1'b0, 8'hFF, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00};
        vecs[18] = '{1'b0, 8'hFF, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00};
        vecs[19] = '{1'b0, 8'hFF, 1'b1, 1'b1, 2'd1, 3'd0, 8'h00};
        vecs[20] = '{1'b0, 8'hFF, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00};

        rst = 1'b1; btn_in = 8'hFF; evt_ready = 1'b1;
        tick(2);
        chk_en = 1'b1;
        check("reset{vld,state,ovf}", 32'({evt_valid, btn_state, ovf}), 32'd0);

        // Latency, single-pulse and hold-under-backpressure vectors
        foreach (vecs[i]) begin
            rst = vecs[i].rst; btn_in = vecs[i].btn; evt_ready = vecs[i].rdy;
            tick(1);
            check($sformatf("vec%0d{vld,typ,key,state}", i),
                  32'({evt_valid, evt_type, evt_key, btn_state}),
                  32'({vecs[i].vld, vecs[i].typ, vecs[i].key, vecs[i].st}));
        end

        // All keys pressed at once with consumer stalled
        tick(5);
        lg.delete();
        btn_in = 8'h00; evt_ready = 1'b0;
        tick(8);
        check("full_head{vld,typ,key}", 32'({evt_valid, evt_type, evt_key}), 32'({1'b1, 2'd0, 3'd0}));
        evt_ready = 1'b1;
        tick(20);
        check("all_press_count", 32'(lg.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_log($sformatf("all_press%0d", i), i, 0, i);
        check("all_press_ovf", 32'(ovf), 32'd0);
        btn_in = 8'hFF;
        tick(20);
        for (int i = 0; i < 8; i++) check_log($sformatf("all_release%0d", i), 8 + i, 1, i);

        // Long press on key 5
        lg.delete();
        btn_in = 8'hDF;
        tick(250);
        btn_in = 8'hFF;
        tick(10);
        check("long_count", 32'(lg.size()), 32'd3);
        check_log("long_press", 0, 0, 5);
        check_log("long_long", 1, 2, 5);
        check_log("long_release", 2, 1, 5);
        if (lg.size() >= 2) check("long_delay", 32'(lg[1].c - lg[0].c), 32'(HOLD));
        else check("long_delay", 32'hFFFF_FFFF, 32'(HOLD));

        // Press/release/press on key 1 while the queue is full
        lg.delete();
        evt_ready = 1'b0;
        btn_in = 8'h0F; tick(6);
        btn_in = 8'h0D; tick(3);
        btn_in = 8'h0F; tick(3);
        btn_in = 8'h0D; tick(3);
        check("merge_ovf", 32'(ovf), 32'd1);
        evt_ready = 1'b1;
        tick(20);
        check("merge_count", 32'(lg.size()), 32'd6);
        for (int i = 0; i < 4; i++) check_log($sformatf("merge_p%0d", 4 + i), i, 0, 4 + i);
        check_log("merge_press1", 4, 0, 1);
        check_log("merge_release1", 5, 1, 1);
        btn_in = 8'hFF;
        tick(15);

        // Reset with three queued events and key 0 held
        lg.delete();
        evt_ready = 1'b0;
        btn_in = 8'hFD; tick(3);
        btn_in = 8'hFF; tick(3);
        btn_in = 8'hFE; tick(6);
        check("pre_rst{vld,ovf}", 32'({evt_valid, ovf}), 32'({1'b1, 1'b1}));
        rst = 1'b1;
        tick(1);
        check("in_rst{vld,state,ovf}", 32'({evt_valid, btn_state, ovf}), 32'd0);
        rst = 1'b0; evt_ready = 1'b1;
        lg.delete();
        tick(10);
        check("post_rst_count", 32'(lg.size()), 32'd1);
        check_log("post_rst_press0", 0, 0, 0);
        btn_in = 8'hFF;
        tick(10);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = int'($urandom_range(0, 7));
                btn_in[b] = ~btn_in[b];
            end
            evt_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/btn_evt.md
BTN_EVT -- requirements
Module: btn_evt

Interface
REQ-001 Parameter BT_WIDTH, default 8: number of debounced button inputs.
REQ-002 Parameter KEY_W, default 3: key-index width; BT_WIDTH SHALL be at most 2**KEY_W.
REQ-003 Parameter ACTIVE_LOW, default 1: when 1, btn_in bit = 0 means pressed.
REQ-004 Parameter HOLD_CYC, default 26'd50_000_000: hold duration in clk cycles before a long-press event (1 s at 50 MHz).
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 btn_in  input  BT_WIDTH  debounced button levels; stable for one or more cycles between changes.
REQ-008 evt_valid  output  1  event word present at the head of the queue.
REQ-009 evt_type  output  2  event type: 2'b00 press, 2'b01 release, 2'b10 long; 2'b11 never driven.
REQ-010 evt_key  output  KEY_W  index of the button that produced the event.
REQ-011 evt_ready  input  1  consumer accepts the head event when high together with evt_valid.
REQ-012 btn_state  output  BT_WIDTH  registered pressed levels, active-high regardless of ACTIVE_LOW.
REQ-013 ovf  output  1  sticky flag: a button edge merged into an already-pending edge of the same kind.

Function
REQ-014 Normalised level p = btn_in XOR {BT_WIDTH{ACTIVE_LOW}}; btn_state SHALL be p registered with 1-cycle delay.
REQ-015 Edge detect on btn_state vs its previous cycle value: rising edge sets press-pending bit k; falling edge sets release-pending bit k.
REQ-016 Arbiter SHALL issue at most one event per cycle into a 4-entry first-word-fall-through queue, and only when the queue is not full or is being popped that same cycle.
REQ-017 Arbiter priority: long pending > lowest-index release pending > lowest-index press pending.
REQ-018 A release for key k SHALL NOT be issued while the press-pending bit for key k is set; that press is issued first.
REQ-019 Issuing an event clears its pending bit in the same cycle; a new edge on the same bit in that cycle SHALL leave the bit set.
REQ-020 If an edge arrives while its pending bit is already set and not being cleared, ovf SHALL be set to 1 until reset; no pending bit is lost while the queue is full.
REQ-021 Long-press tracker, idle: when no key is tracked and btn_state != 0, track the lowest-index pressed key and clear the hold counter.
REQ-022 Long-press tracker, tracking: the hold counter increments each cycle the tracked key stays pressed; on reaching HOLD_CYC-1, set long-pending for that key.
REQ-023 Long-press tracker, done: after long-pending is set, the tracker holds without counting; at most one long event per press.
REQ-024 Any state of the tracker: release of the tracked key returns it to idle in the next cycle; other keys SHALL NOT affect the tracker.
REQ-025 Latency: with an empty queue and no other pending events, a btn_in change at clock edge t SHALL produce evt_valid=1 after clock edge t+3 (1 cycle btn_state register, 1 cycle pending, 1 cycle queue write).
REQ-026 Queue pop occurs on evt_valid & evt_ready; evt_type and evt_key SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-027 Simultaneous pop and push on a full queue SHALL be accepted; occupancy stays 4.
REQ-028 When evt_valid=0, evt_type and evt_key SHALL be 0.

Reset
REQ-029 While rst=1, the following SHALL be 0: btn_state, its previous-cycle copy, all pending bits, queue pointers and count, tracker state, hold counter, ovf, and evt_valid.
REQ-030 A key held through reset SHALL produce one press event after rst deasserts.
REQ-031 Reset asserted mid-hold or with a non-empty queue SHALL discard all queued and pending events with no partial output.

Verification
REQ-032 ACTIVE_LOW=1, evt_ready=1: btn_in 8'hFF -> 8'hFB at edge t; expect evt_valid after edge t+3 with type 00, key 2, then a single 1-cycle pulse.
REQ-033 evt_ready=0: btn_in 8'hFF -> 8'h00 in one step; expect 4 queued events with keys 0,1,2,3 (press); set evt_ready=1 and expect keys 4..7 to follow in order, with ovf=0.
REQ-034 HOLD_CYC=100: press key 5 and hold for 250 cycles; expect exactly one press(5) and one long(5), the long event 100 cycles after tracking begins; release gives release(5).
REQ-035 evt_ready=0 with queue full: toggle key 1 press, release, press; expect ovf=1, and after draining, a press(1) event and no release(1) before it.
REQ-036 Assert rst for 1 cycle with 3 events queued and key 0 held; expect evt_valid=0 during reset, then exactly one press(0) after reset.
